// File: rtl/vc_arbiter_pkg.sv
// Shared constants for the VC arbiter: VC/destination indices and dest-select bit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vc_arbiter_pkg;

    // Source VC encoding, stored in the in-flight source register
    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    // Destination encoding, equal to the value of the word's select bit
    localparam logic D0 = 1'b0;
    localparam logic D1 = 1'b1;

    // The destination is selected by the word's most significant bit
    function automatic int dest_sel_bit(input int data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/vc_arbiter.sv
// Pops VC0/VC1 FIFOs (VC0 priority, bounded VC1 starvation) and routes words to D0/D1 by MSB.
// Latency: pop -> push_Dx/data_out visible 2 cycles later; one word per cycle sustained.
// Backpressure: no pop while either almost_full is high; a word already in flight still pushes.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   empty_fifo_VC0/VC1              source FIFO empty flags
//   data_out_VC0/VC1                source FIFO read data (valid the cycle after pop)
//   almost_full_fifo_D0/D1          destination backpressure
//   pop_VC0_fifo/pop_VC1_fifo       combinational pop strobes
//   push_D0/push_D1, data_out       registered destination write strobes and word
//   count_D0/count_D1               wrapping per-destination forwarded-word counters
//   idle                            registered: nothing queued, in flight or being pushed
module vc_arbiter
    import vc_arbiter_pkg::*;
#(
    parameter int data_width = 6,
    parameter int vc0_burst  = 4,
    parameter int cnt_width  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_fifo_VC0,
    input  logic                  empty_fifo_VC1,
    input  logic [data_width-1:0] data_out_VC0,
    input  logic [data_width-1:0] data_out_VC1,
    input  logic                  almost_full_fifo_D0,
    input  logic                  almost_full_fifo_D1,
    output logic                  pop_VC0_fifo,
    output logic                  pop_VC1_fifo,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [data_width-1:0] data_out,
    output logic [cnt_width-1:0]  count_D0,
    output logic [cnt_width-1:0]  count_D1,
    output logic                  idle
);

    localparam int SEL_BIT = dest_sel_bit(data_width);
    localparam int BURST_W = $clog2(vc0_burst + 1);

    logic [BURST_W-1:0]    burst_cnt;
    logic                  stall;
    logic                  vc0_ne;
    logic                  vc1_ne;
    logic                  burst_full;
    logic                  grant_vc0;
    logic                  grant_vc1;
    logic                  inflight_vld;
    logic                  inflight_src;
    logic [data_width-1:0] word;
    logic                  word_dest;

    // The destination is unknown until the word is read, so either
    // almost_full blocks all pops.
    always_comb begin
        stall      = almost_full_fifo_D0 | almost_full_fifo_D1;
        vc0_ne     = ~empty_fifo_VC0;
        vc1_ne     = ~empty_fifo_VC1;
        burst_full = (burst_cnt == BURST_W'(vc0_burst));
        // VC1 wins when VC0 has nothing, or VC0 has used up its burst allowance.
        grant_vc1  = reset & ~stall & vc1_ne & (~vc0_ne | burst_full);
        grant_vc0  = reset & ~stall & vc0_ne & ~grant_vc1;
    end

    assign pop_VC0_fifo = grant_vc0;
    assign pop_VC1_fifo = grant_vc1;

    // Read data arrives the cycle after the pop; pick it from the VC popped last cycle.
    always_comb begin
        word      = (inflight_src == VC1) ? data_out_VC1 : data_out_VC0;
        word_dest = word[SEL_BIT];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            burst_cnt    <= '0;
            inflight_vld <= 1'b0;
            inflight_src <= VC0;
            push_D0      <= 1'b0;
            push_D1      <= 1'b0;
            data_out     <= '0;
            count_D0     <= '0;
            count_D1     <= '0;
            idle         <= 1'b1;
        end else begin
            // Burst counter only tracks VC0 grants that actually delay a waiting VC1.
            if (grant_vc1) begin
                burst_cnt <= '0;
            end else if (grant_vc0) begin
                if (!vc1_ne) begin
                    burst_cnt <= '0;
                end else if (!burst_full) begin
                    burst_cnt <= burst_cnt + BURST_W'(1);
                end
            end

            inflight_vld <= grant_vc0 | grant_vc1;
            inflight_src <= grant_vc1 ? VC1 : VC0;

            push_D0 <= inflight_vld & (word_dest == D0);
            push_D1 <= inflight_vld & (word_dest == D1);

            // data_out holds its last value when nothing completes.
            if (inflight_vld) begin
                data_out <= word;
                if (word_dest == D1) begin
                    count_D1 <= count_D1 + cnt_width'(1);
                end else begin
                    count_D0 <= count_D0 + cnt_width'(1);
                end
            end

            idle <= empty_fifo_VC0 & empty_fifo_VC1 & ~inflight_vld & ~push_D0 & ~push_D1;
        end
    end

endmodule

// File: tb/tb_vc_arbiter.sv
module tb_vc_arbiter;

    localparam int DW  = 6;
    localparam int CW  = 5;
    localparam int MSB = DW - 1;

    logic          clk;
    logic          reset;
    logic          empty_fifo_VC0;
    logic          empty_fifo_VC1;
    logic [DW-1:0] data_out_VC0;
    logic [DW-1:0] data_out_VC1;
    logic          almost_full_fifo_D0;
    logic          almost_full_fifo_D1;
    logic          pop_VC0_fifo;
    logic          pop_VC1_fifo;
    logic          push_D0;
    logic          push_D1;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count_D0;
    logic [CW-1:0] count_D1;
    logic          idle;

    vc_arbiter #(.data_width(DW), .vc0_burst(4), .cnt_width(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .empty_fifo_VC0      (empty_fifo_VC0),
        .empty_fifo_VC1      (empty_fifo_VC1),
        .data_out_VC0        (data_out_VC0),
        .data_out_VC1        (data_out_VC1),
        .almost_full_fifo_D0 (almost_full_fifo_D0),
        .almost_full_fifo_D1 (almost_full_fifo_D1),
        .pop_VC0_fifo        (pop_VC0_fifo),
        .pop_VC1_fifo        (pop_VC1_fifo),
        .push_D0             (push_D0),
        .push_D1             (push_D1),
        .data_out            (data_out),
        .count_D0            (count_D0),
        .count_D1            (count_D1),
        .idle                (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] word;
        int            due;
    } sb_t;

    typedef struct {
        logic       e0;
        logic       e1;
        logic       af0;
        logic       af1;
        logic [1:0] exp_pop;   // {pop_VC0, pop_VC1}
    } vec_t;

    int            tests;
    int            failed;
    int            cyc;
    int            model_pushes;
    sb_t           sb[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          force_e0;
    logic          force_e1;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic [DW-1:0] last_data;
    logic          inflight_m;
    logic          push_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic update_empties();
        empty_fifo_VC0 = force_e0 | (q0.size() == 0);
        empty_fifo_VC1 = force_e1 | (q1.size() == 0);
    endtask

    task automatic stock(input int vc, input int n, input logic msb);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w      = DW'($urandom_range(0, (1 << DW) - 1));
            w[MSB] = msb;
            if (vc == 0) q0.push_back(w);
            else         q1.push_back(w);
        end
        update_empties();
    endtask

    // One clock cycle: sample pops mid-cycle, advance the FIFO models at the
    // edge, then check every output against the scoreboard and reference model.
    task automatic tick(output logic p0, output logic p1);
        logic  rst_pre;
        logic  exp_idle;
        logic  d1;
        sb_t   e;
        #3;
        p0       = pop_VC0_fifo;
        p1       = pop_VC1_fifo;
        rst_pre  = reset;
        exp_idle = empty_fifo_VC0 & empty_fifo_VC1 & ~inflight_m & ~push_m;
        if (!rst_pre) chk("pop_in_reset", {30'd0, p0, p1}, 32'd0);
        chk("single_pop", {31'd0, p0 & p1}, 32'd0);
        if (p0) begin
            chk("pop_vc0_when_empty", {31'd0, empty_fifo_VC0}, 32'd0);
            if (q0.size() != 0) sb.push_back('{q0[0], cyc + 2});
        end
        if (p1) begin
            chk("pop_vc1_when_empty", {31'd0, empty_fifo_VC1}, 32'd0);
            if (q1.size() != 0) sb.push_back('{q1[0], cyc + 2});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (p0 && q0.size() != 0) data_out_VC0 = q0.pop_front();
        if (p1 && q1.size() != 0) data_out_VC1 = q1.pop_front();
        update_empties();
        if (!rst_pre) begin
            sb.delete();
            cnt0         = '0;
            cnt1         = '0;
            last_data    = '0;
            inflight_m   = 1'b0;
            push_m       = 1'b0;
            model_pushes = 0;
            chk("rst_push",     {30'd0, push_D0, push_D1}, 32'd0);
            chk("rst_data_out", {26'd0, data_out}, 32'd0);
            chk("rst_count_D0", {27'd0, count_D0}, 32'd0);
            chk("rst_count_D1", {27'd0, count_D1}, 32'd0);
            chk("rst_idle",     {31'd0, idle}, 32'd1);
        end else begin
            inflight_m = p0 | p1;
            while (sb.size() != 0 && sb[0].due < cyc) void'(sb.pop_front());
            if (sb.size() != 0 && sb[0].due == cyc) begin
                e  = sb.pop_front();
                d1 = e.word[MSB];
                chk("push_dest", {30'd0, push_D0, push_D1}, {30'd0, ~d1, d1});
                chk("push_data", {26'd0, data_out}, {26'd0, e.word});
                if (d1) cnt1++;
                else    cnt0++;
                last_data = e.word;
                push_m    = 1'b1;
                model_pushes++;
            end else begin
                chk("no_push",   {30'd0, push_D0, push_D1}, 32'd0);
                chk("data_hold", {26'd0, data_out}, {26'd0, last_data});
                push_m = 1'b0;
            end
            chk("count_D0", {27'd0, count_D0}, {27'd0, cnt0});
            chk("count_D1", {27'd0, count_D1}, {27'd0, cnt1});
            chk("idle",     {31'd0, idle}, {31'd0, exp_idle});
        end
    endtask

    task automatic do_reset(input int n);
        logic a, b;
        reset = 1'b0;
        for (int i = 0; i < n; i++) tick(a, b);
        reset = 1'b1;
    endtask

    vec_t vecs[13];

    initial begin
        logic p0, p1;
        logic [1:0] exp_g;
        int   n_seen;

        tests = 0; failed = 0; cyc = 0; model_pushes = 0;
        cnt0 = '0; cnt1 = '0; last_data = '0; inflight_m = 1'b0; push_m = 1'b0;
        force_e0 = 1'b0; force_e1 = 1'b0;
        data_out_VC0 = '0; data_out_VC1 = '0;
        almost_full_fifo_D0 = 1'b0; almost_full_fifo_D1 = 1'b0;
        reset = 1'b0;

        // Grant vectors from a cleared burst counter; rows depend on their predecessors.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10};  // both ready: VC0, burst 1
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01};  // VC0 empty: VC1, burst 0
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10};  // VC1 empty: VC0, burst stays 0
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00};  // D0 almost full
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00};  // D1 almost full
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00};  // nothing to pop
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10};  // burst 1
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10};  // burst 2
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00};  // stall beats VC1
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10};  // burst 3
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10};  // burst 4
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01};  // forced VC1
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10};

        // Reset for two cycles with VC0 non-empty, then first pop on release.
        q0.push_back(6'h05);
        q0.push_back(6'h25);
        update_empties();
        do_reset(2);
        tick(p0, p1);
        chk("first_pop_after_reset", {30'd0, p0, p1}, 32'd2);
        tick(p0, p1);
        chk("t2_push_D0", {30'd0, push_D0, push_D1}, 32'd2);
        chk("t2_data_05", {26'd0, data_out}, 32'h05);
        tick(p0, p1);
        chk("t2_push_D1", {30'd0, push_D0, push_D1}, 32'd1);
        chk("t2_data_25", {26'd0, data_out}, 32'h25);
        chk("t2_count_D0", {27'd0, count_D0}, 32'd1);
        chk("t2_count_D1", {27'd0, count_D1}, 32'd1);
        tick(p0, p1);

        // Table-driven grant vectors.
        stock(0, 20, 1'b0);
        stock(1, 20, 1'b1);
        for (int i = 0; i < 13; i++) begin
            force_e0            = vecs[i].e0;
            force_e1            = vecs[i].e1;
            almost_full_fifo_D0 = vecs[i].af0;
            almost_full_fifo_D1 = vecs[i].af1;
            update_empties();
            tick(p0, p1);
            chk($sformatf("vec%0d_grant", i), {30'd0, p0, p1}, {30'd0, vecs[i].exp_pop});
        end
        force_e0 = 1'b0; force_e1 = 1'b0;
        almost_full_fifo_D0 = 1'b0; almost_full_fifo_D1 = 1'b0;
        update_empties();

        // Continuous contention: VC0 x4 then one VC1, repeating.
        do_reset(1);
        stock(0, 12, 1'b0);
        stock(1, 12, 1'b1);
        for (int i = 0; i < 10; i++) begin
            exp_g = (i % 5 == 4) ? 2'b01 : 2'b10;
            tick(p0, p1);
            chk($sformatf("burst_seq%0d", i), {30'd0, p0, p1}, {30'd0, exp_g});
        end

        // Stall on D1 for 3 cycles during VC0 streaming.
        q1.delete();
        update_empties();
        stock(0, 10, 1'b0);
        tick(p0, p1);
        tick(p0, p1);
        almost_full_fifo_D1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(p0, p1);
            chk($sformatf("stall_no_pop%0d", i), {30'd0, p0, p1}, 32'd0);
            if (i == 0) chk("stall_inflight_push", {31'd0, push_D0 | push_D1}, 32'd1);
        end
        almost_full_fifo_D1 = 1'b0;
        tick(p0, p1);
        chk("stall_resume_pop", {30'd0, p0, p1}, 32'd2);

        // 33 words to D0: counter wraps 31 -> 0 -> 1.
        q0.delete();
        q1.delete();
        update_empties();
        do_reset(1);
        stock(0, 33, 1'b0);
        n_seen = 0;
        for (int i = 0; i < 60 && n_seen < 33; i++) begin
            tick(p0, p1);
            if (model_pushes != n_seen) begin
                n_seen = model_pushes;
                if (n_seen == 31) chk("wrap_31", {27'd0, count_D0}, 32'd31);
                if (n_seen == 32) chk("wrap_0",  {27'd0, count_D0}, 32'd0);
                if (n_seen == 33) chk("wrap_1",  {27'd0, count_D0}, 32'd1);
            end
        end
        chk("wrap_pushes_seen", n_seen, 32'd33);

        // Reset the cycle after a pop drops the in-flight word.
        do_reset(1);
        stock(0, 1, 1'b1);
        tick(p0, p1);
        chk("t6_pop", {30'd0, p0, p1}, 32'd2);
        do_reset(1);
        chk("t6_no_push", {30'd0, push_D0, push_D1}, 32'd0);
        for (int i = 0; i < 3; i++) tick(p0, p1);
        chk("t6_idle", {31'd0, idle}, 32'd1);
        chk("t6_count_D1", {27'd0, count_D1}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
